// File: rtl/rgb_pwm_frame_driver_if.sv
// Duty-triple handshake between the colour generator and the PWM frame driver.
interface rgb_pwm_frame_driver_if #(
    parameter int PWM_BITS = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [PWM_BITS-1:0] in_r;
    logic [PWM_BITS-1:0] in_g;
    logic [PWM_BITS-1:0] in_b;
    logic [7:0]          brightness;

    // Upstream producer side: offers a duty triple and a brightness scale.
    modport master (
        output in_valid,
        output in_r,
        output in_g,
        output in_b,
        output brightness,
        input  in_ready
    );

    // PWM driver side: accepts one triple whenever it reports ready.
    modport slave (
        input  in_valid,
        input  in_r,
        input  in_g,
        input  in_b,
        input  brightness,
        output in_ready
    );
endinterface

// File: rtl/rgb_pwm_frame_driver.sv
// RGB PWM output stage. Duty triples arrive over a valid/ready handshake, are
// scaled by a global brightness, and are swapped into the active duty set only
// at PWM frame boundaries so that colour changes never produce a torn frame.
module rgb_pwm_frame_driver #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rgb_pwm_frame_driver_if.slave  inBus,
    output logic                   frame_start,
    output logic                   RGB_R,
    output logic                   RGB_G,
    output logic                   RGB_B
);

    localparam int                PSC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0]  PSC_LAST = PSC_W'(PRESCALE - 1);
    localparam int                PROD_W   = PWM_BITS + 9;

    typedef enum logic [1:0] {
        EMPTY,
        SCALE,
        PENDING
    } state_t;

    state_t              r_state;
    logic                r_ready;
    logic [PSC_W-1:0]    r_prescCnt;
    logic [PWM_BITS-1:0] r_pwmCnt;

    logic [PWM_BITS-1:0] r_capR;
    logic [PWM_BITS-1:0] r_capG;
    logic [PWM_BITS-1:0] r_capB;
    logic [7:0]          r_capBright;

    logic [PWM_BITS-1:0] r_shadowR;
    logic [PWM_BITS-1:0] r_shadowG;
    logic [PWM_BITS-1:0] r_shadowB;

    logic [PWM_BITS-1:0] r_activeR;
    logic [PWM_BITS-1:0] r_activeG;
    logic [PWM_BITS-1:0] r_activeB;

    logic                w_stepEnd;
    logic                w_boundary;
    logic                w_load;
    logic [PWM_BITS-1:0] w_pwmNext;
    logic [8:0]          w_scale9;
    logic [PROD_W-1:0]   w_prodR;
    logic [PROD_W-1:0]   w_prodG;
    logic [PROD_W-1:0]   w_prodB;
    logic [PWM_BITS-1:0] w_activeNextR;
    logic [PWM_BITS-1:0] w_activeNextG;
    logic [PWM_BITS-1:0] w_activeNextB;

    // The last clk of the last PWM step is the frame boundary; a pending update
    // is committed on exactly that edge.
    assign w_stepEnd  = (r_prescCnt == PSC_LAST);
    assign w_boundary = w_stepEnd && (r_pwmCnt == {PWM_BITS{1'b1}});
    assign w_load     = (r_state == PENDING) && w_boundary;
    assign w_pwmNext  = w_stepEnd ? (r_pwmCnt + PWM_BITS'(1)) : r_pwmCnt;

    // Brightness 255 maps to a multiplier of 256, so the >>8 returns the duty
    // unchanged; the product width leaves room for the full range.
    assign w_scale9 = {1'b0, r_capBright} + 9'd1;
    assign w_prodR  = PROD_W'(r_capR) * PROD_W'(w_scale9);
    assign w_prodG  = PROD_W'(r_capG) * PROD_W'(w_scale9);
    assign w_prodB  = PROD_W'(r_capB) * PROD_W'(w_scale9);

    // Duty values that will be in force after this edge, so the registered
    // compare lines up with the registered frame_start pulse.
    assign w_activeNextR = w_load ? r_shadowR : r_activeR;
    assign w_activeNextG = w_load ? r_shadowG : r_activeG;
    assign w_activeNextB = w_load ? r_shadowB : r_activeB;

    assign inBus.in_ready = r_ready;

    // Prescaler and PWM step counter; the step counter wraps once per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescCnt <= '0;
            r_pwmCnt   <= '0;
        end else begin
            r_prescCnt <= w_stepEnd ? '0 : (r_prescCnt + PSC_W'(1));
            r_pwmCnt   <= w_pwmNext;
        end
    end

    // Update FSM: capture a triple, scale it once, then wait for the boundary
    // to swap it into the active set while refusing further input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_ready     <= 1'b1;
            r_capR      <= '0;
            r_capG      <= '0;
            r_capB      <= '0;
            r_capBright <= '0;
            r_shadowR   <= '0;
            r_shadowG   <= '0;
            r_shadowB   <= '0;
            r_activeR   <= '0;
            r_activeG   <= '0;
            r_activeB   <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (inBus.in_valid) begin
                        r_capR      <= inBus.in_r;
                        r_capG      <= inBus.in_g;
                        r_capB      <= inBus.in_b;
                        r_capBright <= inBus.brightness;
                        r_state     <= SCALE;
                        r_ready     <= 1'b0;
                    end
                end
                SCALE: begin
                    r_shadowR <= PWM_BITS'(w_prodR >> 8);
                    r_shadowG <= PWM_BITS'(w_prodG >> 8);
                    r_shadowB <= PWM_BITS'(w_prodB >> 8);
                    r_state   <= PENDING;
                end
                PENDING: begin
                    if (w_boundary) begin
                        r_activeR <= r_shadowR;
                        r_activeG <= r_shadowG;
                        r_activeB <= r_shadowB;
                        r_state   <= EMPTY;
                        r_ready   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Registered frame marker and PWM compares, both aligned to the first cycle
    // of each frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
            RGB_R       <= 1'b0;
            RGB_G       <= 1'b0;
            RGB_B       <= 1'b0;
        end else begin
            frame_start <= w_boundary;
            RGB_R       <= (w_pwmNext < w_activeNextR);
            RGB_G       <= (w_pwmNext < w_activeNextG);
            RGB_B       <= (w_pwmNext < w_activeNextB);
        end
    end

endmodule
